// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with a one-entry output buffer.
// Frames start on sin_start, shift in WIDTH bits MSB- or LSB-first, and the
// completed word is held until the consumer takes it.
// Optional feature macro: PARITY_CHECK_EN (adds one even-parity bit per frame
// and reports mismatches on out_perr).
module serial_word_rx #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_start,
    input  logic             lsb_first,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_perr,
    output logic             overrun,
    output logic             frame_abort
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             lsb_q, lsb_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_perr_q, out_perr_d;
    logic             overrun_q, overrun_d;
    logic             abort_q, abort_d;

    logic             done_c;
    logic [WIDTH-1:0] word_c;
    logic             perr_c;
    logic [WIDTH-1:0] shifted_c;
    logic [WIDTH-1:0] first_word_c;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            lsb_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_perr_q  <= 1'b0;
            overrun_q   <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            lsb_q       <= lsb_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_perr_q  <= out_perr_d;
            overrun_q   <= overrun_d;
            abort_q     <= abort_d;
        end
    end

    // Frame FSM, shifter and output-buffer next state
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        lsb_d        = lsb_q;
        done_c       = 1'b0;
        word_c       = shift_q;
        perr_c       = 1'b0;
        abort_d      = 1'b0;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_perr_d   = out_perr_q;
        overrun_d    = 1'b0;

        // Shift direction follows the order latched on the frame's first bit
        shifted_c    = lsb_q ? {sin_data, shift_q[WIDTH-1:1]}
                             : {shift_q[WIDTH-2:0], sin_data};
        // A start bit lands where a one-bit-old frame would have it
        first_word_c = lsb_first ? {sin_data, {(WIDTH-1){1'b0}}}
                                 : {{(WIDTH-1){1'b0}}, sin_data};

        if (sin_valid) begin
            if (sin_start) begin
                // Any start restarts the frame; mid-frame it also flags an abort
                abort_d = (state_q != S_IDLE);
                shift_d = first_word_c;
                lsb_d   = lsb_first;
                cnt_d   = CW'(1);
                state_d = S_SHIFT;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_d = S_IDLE;
                    end
                    S_SHIFT: begin
                        shift_d = shifted_c;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_d = '0;
`ifdef PARITY_CHECK_EN
                            state_d = S_PARITY;
`else
                            state_d = S_IDLE;
                            done_c  = 1'b1;
                            word_c  = shifted_c;
`endif
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
`ifdef PARITY_CHECK_EN
                    S_PARITY: begin
                        // Even parity: data bits XOR parity bit must be 0
                        state_d = S_IDLE;
                        done_c  = 1'b1;
                        word_c  = shift_q;
                        perr_c  = (^shift_q) ^ sin_data;
                    end
`endif
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end

        // Output buffer: a transfer frees the slot in the same cycle a new word may load
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (done_c) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = word_c;
                out_perr_d  = perr_c;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_perr    = out_perr_q;
    assign overrun     = overrun_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (WIDTH=8); also covers PARITY_CHECK_EN builds.
module tb_serial_word_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       sin_valid;
    logic       sin_data;
    logic       sin_start;
    logic       lsb_first;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_perr;
    logic       overrun;
    logic       frame_abort;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_word_rx #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .sin_valid   (sin_valid),
        .sin_data    (sin_data),
        .sin_start   (sin_start),
        .lsb_first   (lsb_first),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_perr    (out_perr),
        .overrun     (overrun),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seq;     // seq[7] is sent first
        logic       lsb;
        logic       par;     // even-parity bit for the resulting word
        int         gap_at;  // insert idles after this bit index, -1 for none
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sin_valid = 1'b0;
        sin_data  = 1'b1;
        sin_start = 1'b1;   // must be ignored while invalid
        repeat (n) tick();
        sin_start = 1'b0;
    endtask

    task automatic send_bit(input logic d, input logic st, input logic lsb);
        sin_valid = 1'b1;
        sin_data  = d;
        sin_start = st;
        lsb_first = lsb;
        tick();
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    // lsb_first is flipped on non-start bits: only the first bit's value may count
    task automatic send_frame(input logic [7:0] seq, input logic lsb, input logic par,
                              input int gap_at, input int gap_len, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
`ifndef PARITY_CHECK_EN
            if (i == 7) out_ready = rdy_last;
`endif
            send_bit(seq[7-i], (i == 0), (i == 0) ? lsb : ~lsb);
            if (i == gap_at) idle(gap_len);
        end
`ifdef PARITY_CHECK_EN
        out_ready = rdy_last;
        send_bit(par, 1'b0, ~lsb);
`else
        sin_data = par;
`endif
    endtask

    initial begin
        vecs[0] = '{seq: 8'b10110010, lsb: 1'b0, par: 1'b0, gap_at: -1, exp: 8'hB2};
        vecs[1] = '{seq: 8'b10110010, lsb: 1'b1, par: 1'b0, gap_at: 3,  exp: 8'h4D};
        vecs[2] = '{seq: 8'b11110000, lsb: 1'b1, par: 1'b0, gap_at: -1, exp: 8'h0F};
        vecs[3] = '{seq: 8'b00000001, lsb: 1'b0, par: 1'b1, gap_at: 5,  exp: 8'h01};
        vecs[4] = '{seq: 8'b00000001, lsb: 1'b1, par: 1'b1, gap_at: -1, exp: 8'h80};
        vecs[5] = '{seq: 8'b11111111, lsb: 1'b0, par: 1'b0, gap_at: 0,  exp: 8'hFF};

        reset     = 1'b1;
        sin_valid = 1'b0;
        sin_data  = 1'b0;
        sin_start = 1'b0;
        lsb_first = 1'b0;
        out_ready = 1'b1;
        #3;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_perr", 32'(out_perr), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_abort", 32'(frame_abort), 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Bits without a start are ignored in IDLE
        for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0, 1'b0);
        tick();
        check("idle_ignore_valid", 32'(out_valid), 0);

        // Table of complete frames with the consumer always ready
        for (int v = 0; v < 6; v++) begin
            idle(2);
            send_frame(vecs[v].seq, vecs[v].lsb, vecs[v].par, vecs[v].gap_at, 3, 1'b1);
            check($sformatf("vec%0d_valid", v), 32'(out_valid), 1);
            check($sformatf("vec%0d_data", v), 32'(out_data), 32'(vecs[v].exp));
            check($sformatf("vec%0d_perr", v), 32'(out_perr), 0);
            check($sformatf("vec%0d_overrun", v), 32'(overrun), 0);
            check($sformatf("vec%0d_abort", v), 32'(frame_abort), 0);
            idle(1);
            check($sformatf("vec%0d_valid_drop", v), 32'(out_valid), 0);
        end

        // A completed frame needs a fresh start: eight more bits produce nothing
        for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        tick();
        check("nostart_valid", 32'(out_valid), 0);

        // Overrun: second word dropped while the consumer stalls
        out_ready = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, -1, 0, 1'b0);
        check("ovr_first_valid", 32'(out_valid), 1);
        check("ovr_first_data", 32'(out_data), 32'h A5);
        send_frame(8'h3C, 1'b0, 1'b0, -1, 0, 1'b0);
        check("ovr_pulse", 32'(overrun), 1);
        check("ovr_hold_data", 32'(out_data), 32'h A5);
        check("ovr_hold_valid", 32'(out_valid), 1);
        idle(1);
        check("ovr_pulse_end", 32'(overrun), 0);
        check("ovr_still_data", 32'(out_data), 32'h A5);
        out_ready = 1'b1;
        idle(1);
        check("ovr_drain_valid", 32'(out_valid), 0);

        // Completion coincident with a transfer reloads without overrun
        out_ready = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, -1, 0, 1'b0);
        check("same_cyc_first", 32'(out_data), 32'h A5);
        send_frame(8'h3C, 1'b0, 1'b0, -1, 0, 1'b1);
        check("same_cyc_valid", 32'(out_valid), 1);
        check("same_cyc_data", 32'(out_data), 32'h 3C);
        check("same_cyc_overrun", 32'(overrun), 0);
        idle(1);
        check("same_cyc_drain", 32'(out_valid), 0);

        // Start after five bits aborts the partial frame; 0x0F follows
        send_bit(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b1);
        check("abort_none_yet", 32'(frame_abort), 0);
        send_bit(1'b0, 1'b1, 1'b0);
        check("abort_pulse", 32'(frame_abort), 1);
        send_bit(1'b0, 1'b0, 1'b1);
        check("abort_pulse_end", 32'(frame_abort), 0);
        begin
            logic [7:0] rest;
            rest = 8'h0F;
            for (int i = 2; i < 8; i++) send_bit(rest[7-i], 1'b0, 1'b1);
        end
`ifdef PARITY_CHECK_EN
        send_bit(1'b0, 1'b0, 1'b1);
`endif
        check("abort_word_valid", 32'(out_valid), 1);
        check("abort_word_data", 32'(out_data), 32'h 0F);
        idle(1);

        // Reset mid-frame with a word held: everything clears, no pulses
        out_ready = 1'b0;
        send_frame(8'hB2, 1'b0, 1'b0, -1, 0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 0);
        check("midrst_data", 32'(out_data), 0);
        check("midrst_perr", 32'(out_perr), 0);
        tick();
        reset = 1'b0;
        tick();
        check("midrst_overrun", 32'(overrun), 0);
        check("midrst_abort", 32'(frame_abort), 0);
        check("midrst_valid2", 32'(out_valid), 0);
        for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 1'b0);
        check("midrst_no_resume", 32'(out_valid), 0);
        out_ready = 1'b1;
        send_frame(8'b01001101, 1'b0, 1'b0, -1, 0, 1'b1);
        check("postrst_valid", 32'(out_valid), 1);
        check("postrst_data", 32'(out_data), 32'h 4D);
        check("postrst_abort", 32'(frame_abort), 0);
        idle(1);

`ifdef PARITY_CHECK_EN
        send_frame(8'h07, 1'b0, 1'b0, -1, 0, 1'b1);
        check("par_bad_valid", 32'(out_valid), 1);
        check("par_bad_data", 32'(out_data), 32'h 07);
        check("par_bad_perr", 32'(out_perr), 1);
        idle(1);
        send_frame(8'h07, 1'b0, 1'b1, -1, 0, 1'b1);
        check("par_good_data", 32'(out_data), 32'h 07);
        check("par_good_perr", 32'(out_perr), 0);
        idle(1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 Parameter: WIDTH, 8, data word width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  rising-edge clock for all sequential logic.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: sin_valid  input  1  qualifies sin_data and sin_start in the current cycle.
REQ-005 Port: sin_data  input  1  serial data bit.
REQ-006 Port: sin_start  input  1  marks the first bit of a frame; meaningful only when sin_valid=1.
REQ-007 Port: lsb_first  input  1  bit order, 1=LSB first, 0=MSB first; sampled only on the frame's first bit.
REQ-008 Port: out_valid  output  1  a received word is held in the output buffer.
REQ-009 Port: out_ready  input  1  consumer accepts the word; transfer occurs when out_valid=1 and out_ready=1.
REQ-010 Port: out_data  output  WIDTH  received word.
REQ-011 Port: out_perr  output  1  parity error flag accompanying out_data; valid while out_valid=1.
REQ-012 Port: overrun  output  1  one-cycle pulse: a completed word was dropped.
REQ-013 Port: frame_abort  output  1  one-cycle pulse: an in-progress frame was restarted by sin_start.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT, and PARITY (PARITY exists only when PARITY_CHECK_EN is defined).
REQ-015 In IDLE, a bit with sin_valid=1 and sin_start=0 SHALL be ignored.
REQ-016 In IDLE, sin_valid=1 with sin_start=1 SHALL capture the bit as bit 1 of the frame, latch lsb_first, set the bit count to 1, and go to SHIFT.
REQ-017 In MSB-first mode, each accepted bit SHALL shift the register left, with the new bit entering at [0].
REQ-018 In LSB-first mode, each accepted bit SHALL shift the register right, with the new bit entering at [WIDTH-1].
REQ-019 Cycles with sin_valid=0 SHALL leave the shift register, count, and state unchanged; gaps of any length are allowed.
REQ-020 In SHIFT or PARITY, sin_valid=1 with sin_start=1 SHALL pulse frame_abort, discard the partial word, and restart the frame with the current bit as bit 1.
REQ-021 When data bit WIDTH is accepted, the FSM SHALL go to PARITY if enabled; otherwise the word completes and the FSM returns to IDLE.
REQ-022 When a word completes in cycle N, out_data and out_valid=1 SHALL appear at cycle N+1.
REQ-023 out_valid SHALL stay high, with out_data and out_perr stable, until the cycle in which out_ready=1.
REQ-024 If a word completes while the buffer is full and out_ready=0, the new word SHALL be dropped, the held word kept, and overrun pulsed at N+1.
REQ-025 If a word completes in the same cycle as an out_ready transfer, the new word SHALL load with no overrun and out_valid SHALL remain 1.
REQ-026 The bit count SHALL wrap to 0 at frame completion; the frame following a completed word needs a fresh sin_start.

Reset
REQ-027 On reset, the FSM SHALL enter IDLE, and the shift register, count, out_data, out_valid, out_perr, overrun, and frame_abort SHALL all clear to 0.
REQ-028 Reset asserted mid-frame or with out_valid=1 SHALL discard all data, with no overrun or frame_abort pulse.
REQ-029 After reset deassertion, the first frame SHALL be accepted on the first valid sin_start.

Configuration
REQ-030 With PARITY_CHECK_EN defined, one parity bit SHALL follow the data bits; out_perr=1 when the data XOR the parity bit is 1 (even parity), and the word is still delivered.
REQ-031 With PARITY_CHECK_EN undefined, a frame SHALL be exactly WIDTH bits, out_perr SHALL be constant 0, and no PARITY state SHALL exist.

Verification
REQ-032 WIDTH=8, MSB-first, bits 1,0,1,1,0,0,1,0 with start on the first, out_ready=1 -> out_data=8'hB2, out_valid for exactly 1 cycle, one cycle after the last bit.
REQ-033 The same bits in LSB-first mode, with 3 idle cycles inserted mid-frame -> out_data=8'h4D.
REQ-034 Two frames 8'hA5 then 8'h3C with out_ready=0 throughout -> out_data stays 8'hA5, overrun pulses once; then out_ready=1 -> the transfer completes and out_valid drops.
REQ-035 sin_start reasserted after 5 bits, followed by a full frame 8'h0F -> frame_abort pulses once and out_data=8'h0F.
REQ-036 PARITY_CHECK_EN defined, 8'h07 with parity bit 0 -> out_perr=1; with parity bit 1 -> out_perr=0. Reset asserted mid-frame -> all outputs 0 and the next frame is received correctly.
